// File: rtl/lfsr_req_arbiter_if.sv
// Request/grant bus between random-byte consumers and the shared LFSR arbiter.
// The master side drives requests and seeding; the slave side is the arbiter.
interface lfsr_req_arbiter_if #(
  parameter int unsigned N_REQ = 2
) ();
  logic             seed_load;
  logic [7:0]       seed_in;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             rnd_valid;
  logic [7:0]       rnd_data;
  logic [15:0]      gnt_count;

  modport master (
    output seed_load, seed_in, req,
    input  gnt, rnd_valid, rnd_data, gnt_count
  );

  modport slave (
    input  seed_load, seed_in, req,
    output gnt, rnd_valid, rnd_data, gnt_count
  );
endinterface

// File: rtl/lfsr_req_arbiter.sv
// Round-robin arbiter handing out one byte of a shared 8-bit Fibonacci LFSR
// per grant; the LFSR advances only when a value is served.
module lfsr_req_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input  logic                clk,
  input  logic                rst_n,
  lfsr_req_arbiter_if.slave   bus
);
  localparam int unsigned      PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned      CNT_W    = 16;
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [7:0]         lfsr;
  logic [PTR_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]   gnt_q;
  logic [7:0]         data_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [7:0]         lfsr_step;
  logic [N_REQ-1:0]   winner_onehot;
  logic [PTR_W-1:0]   rr_ptr_next;

  assign lfsr_step     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign winner_onehot = ONE << winner;
  assign rr_ptr_next   = (winner == LAST) ? '0 : winner + PTR_W'(1);

  // First asserted request at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && |(bus.req & (ONE << idx))) begin
        winner = PTR_W'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED_EFF;
      rr_ptr <= '0;
      gnt_q  <= '0;
      data_q <= 8'h00;
      cnt_q  <= '0;
    end else if (bus.seed_load) begin
      state  <= IDLE;
      lfsr   <= (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
      gnt_q  <= '0;
    end else if (found) begin
      state  <= GRANT;
      gnt_q  <= winner_onehot;
      data_q <= lfsr;
      lfsr   <= lfsr_step;
      rr_ptr <= rr_ptr_next;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      state  <= IDLE;
      gnt_q  <= '0;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd_valid = (state == GRANT);
  assign bus.rnd_data  = data_q;
  assign bus.gnt_count = cnt_q;
endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Directed bench for lfsr_req_arbiter: per-cycle compare against a behavioural
// model plus hand-computed expectations for the documented scenarios.
module tb_lfsr_req_arbiter;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lfsr_req_arbiter_if #(.N_REQ(N)) ifc  ();
  lfsr_req_arbiter_if #(.N_REQ(N)) ifc0 ();

  assign ifc0.seed_load = ifc.seed_load;
  assign ifc0.seed_in   = ifc.seed_in;
  assign ifc0.req       = ifc.req;

  lfsr_req_arbiter #(.N_REQ(N), .SEED(8'h01)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  lfsr_req_arbiter #(.N_REQ(N), .SEED(8'h00)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: spec rules in plain arithmetic.
  logic [7:0]   m_lfsr;
  int           m_ptr;
  logic [N-1:0] m_gnt;
  logic         m_valid;
  logic [7:0]   m_data;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr  <= 8'h01;
      m_ptr   <= 0;
      m_gnt   <= '0;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_cnt   <= 0;
    end else if (ifc.seed_load) begin
      m_lfsr  <= (ifc.seed_in == 8'h00) ? 8'h01 : ifc.seed_in;
      m_gnt   <= '0;
      m_valid <= 1'b0;
    end else if (ifc.req != '0) begin
      int w;
      bit hit;
      logic [N-1:0] req_v;
      w = 0;
      hit = 0;
      req_v = ifc.req;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!hit && req_v[c]) begin
          w = c;
          hit = 1;
        end
      end
      m_gnt   <= N'(1) << w;
      m_valid <= 1'b1;
      m_data  <= m_lfsr;
      m_lfsr  <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_ptr   <= (w + 1) % N;
      m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      m_gnt   <= '0;
      m_valid <= 1'b0;
    end
  end

  // Every-cycle comparison of both builds against the model.
  always @(posedge clk) begin
    #1;
    check("gnt",        32'(ifc.gnt),        32'(m_gnt));
    check("rnd_valid",  32'(ifc.rnd_valid),  32'(m_valid));
    check("rnd_data",   32'(ifc.rnd_data),   32'(m_data));
    check("gnt_count",  32'(ifc.gnt_count),  32'(m_cnt));
    check("seed0_gnt",  32'(ifc0.gnt),       32'(m_gnt));
    check("seed0_data", 32'(ifc0.rnd_data),  32'(m_data));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp_seq [4];
  logic [N-1:0] exp_alt [4];
  bit [255:0] seen;
  int dups;
  logic [7:0] v;

  initial begin
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08};
    exp_alt = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0;
    ifc.seed_load = 1'b0;
    ifc.seed_in   = 8'h00;
    ifc.req       = '0;
    cyc();
    cyc();
    check("rst_gnt",   32'(ifc.gnt),       32'h0);
    check("rst_valid", 32'(ifc.rnd_valid), 32'h0);
    check("rst_data",  32'(ifc.rnd_data),  32'h0);
    check("rst_count", 32'(ifc.gnt_count), 32'h0);
    rst_n = 1'b1;

    // T1: single requester held
    ifc.req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t1_gnt",  32'(ifc.gnt),      32'h1);
      check("t1_data", 32'(ifc.rnd_data), 32'(exp_seq[i]));
      if (i == 0) check("t4_seed0_first", 32'(ifc0.rnd_data), 32'h01);
    end
    ifc.req = '0;
    cyc();
    check("t1_count", 32'(ifc.gnt_count), 32'd4);
    check("t1_idle",  32'(ifc.rnd_valid), 32'h0);
    check("t1_hold",  32'(ifc.rnd_data),  32'h08);

    // T2: both requesters alternate
    do_reset();
    ifc.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t2_gnt",  32'(ifc.gnt),      32'(exp_alt[i]));
      check("t2_data", 32'(ifc.rnd_data), 32'(exp_seq[i]));
    end
    ifc.req = '0;
    cyc();

    // T3: seed load wins over request
    ifc.seed_load = 1'b1;
    ifc.seed_in   = 8'h8E;
    ifc.req       = 2'b01;
    cyc();
    check("t3_nognt",  32'(ifc.gnt),       32'h0);
    check("t3_novld",  32'(ifc.rnd_valid), 32'h0);
    ifc.seed_load = 1'b0;
    cyc();
    check("t3_data0", 32'(ifc.rnd_data), 32'h8E);
    check("t3_gnt0",  32'(ifc.gnt),      32'h1);
    cyc();
    check("t3_data1", 32'(ifc.rnd_data), 32'h1C);
    ifc.req = '0;
    cyc();

    // T4: zero seed replaced by 01
    ifc.seed_load = 1'b1;
    ifc.seed_in   = 8'h00;
    cyc();
    ifc.seed_load = 1'b0;
    ifc.req       = 2'b01;
    cyc();
    check("t4_data0", 32'(ifc.rnd_data), 32'h01);
    cyc();
    check("t4_data1", 32'(ifc.rnd_data), 32'h02);
    ifc.req = '0;
    cyc();

    // T5: full period
    do_reset();
    seen = '0;
    dups = 0;
    ifc.req = 2'b01;
    for (int i = 0; i < 255; i++) begin
      cyc();
      v = ifc.rnd_data;
      if (v == 8'h00 || seen[v]) dups++;
      seen[v] = 1'b1;
    end
    check("t5_distinct", 32'(dups), 32'd0);
    check("t5_count",    32'(ifc.gnt_count), 32'd255);
    cyc();
    check("t5_wrap", 32'(ifc.rnd_data), 32'h01);
    ifc.req = '0;
    cyc();

    // T6: async reset mid-stream
    ifc.req = 2'b11;
    cyc();
    cyc();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_gnt_drop",   32'(ifc.gnt),       32'h0);
    check("t6_valid_drop", 32'(ifc.rnd_valid), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    check("t6_gnt",  32'(ifc.gnt),      32'h1);
    check("t6_data", 32'(ifc.rnd_data), 32'h01);
    ifc.req = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
